// File: rtl/det_event_logger.sv
// det_event_logger: timestamps detection pulses into a FIFO, with saturating
// event/drop counters and a sticky overflow flag.
module det_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   det_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [TS_W-1:0]        out_ts,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       evt_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  logic [TS_W-1:0]  r_ts;
  logic [TS_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_level;
  logic [CNT_W-1:0] r_evt, r_drop;
  logic             r_ovf;
  logic             w_pop, w_push, w_full;
  assign w_full = r_level == L_FULL;
  assign w_pop  = (r_level != '0) && out_ready;
  // a full FIFO still accepts a push when the head is leaving in the same cycle
  assign w_push = det_in && (!w_full || w_pop);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_ts    <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_evt   <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_ts    <= r_ts + 1'b1;
      r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      if (w_push) begin
        r_mem[r_wr] <= r_ts;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (det_in) r_evt <= (r_evt != '1) ? r_evt + 1'b1 : r_evt;
      if (det_in && !w_push) begin
        r_drop <= (r_drop != '1) ? r_drop + 1'b1 : r_drop;
        r_ovf  <= 1'b1;
      end
    end
  end
  assign out_valid  = r_level != '0;
  assign out_ts     = r_mem[r_rd];
  assign fifo_level = r_level;
  assign evt_count  = r_evt;
  assign drop_count = r_drop;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_det_event_logger.sv
// tb_det_event_logger: directed scenario tests for det_event_logger.
module tb_det_event_logger;
  logic        clk = 0, rst = 1, clear = 0, det_in = 0, out_ready = 0;
  logic        out_valid, overflow;
  logic [15:0] out_ts, evt_count, drop_count;
  logic [3:0]  fifo_level;
  logic        clear_w = 0, det_w = 0, ready_w = 0;
  logic        valid_w, ovf_w;
  logic [3:0]  ts_w, level_w;
  logic [15:0] evt_w, drop_w;
  int pass_cnt = 0, total = 0;

  det_event_logger dut (
    .clk(clk), .rst(rst), .clear(clear), .det_in(det_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_ts(out_ts), .fifo_level(fifo_level),
    .evt_count(evt_count), .drop_count(drop_count), .overflow(overflow)
  );

  det_event_logger #(.TS_W(4)) u_w (
    .clk(clk), .rst(rst), .clear(clear_w), .det_in(det_w), .out_ready(ready_w),
    .out_valid(valid_w), .out_ts(ts_w), .fifo_level(level_w),
    .evt_count(evt_w), .drop_count(drop_w), .overflow(ovf_w)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1; det_in = 0; out_ready = 0;
    tick();
    clear = 0;
  endtask

  task automatic test_reset();
    rst = 1; det_in = 0; out_ready = 0;
    tick(2);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0d exp 0", out_valid); else pass_cnt++;
    total++; if (out_ts !== 16'd0) $display("FAIL reset_ts got %0d exp 0", out_ts); else pass_cnt++;
    total++; if (fifo_level !== 4'd0) $display("FAIL reset_level got %0d exp 0", fifo_level); else pass_cnt++;
    total++; if (evt_count !== 16'd0) $display("FAIL reset_evt got %0d exp 0", evt_count); else pass_cnt++;
    total++; if (drop_count !== 16'd0) $display("FAIL reset_drop got %0d exp 0", drop_count); else pass_cnt++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %0d exp 0", overflow); else pass_cnt++;
    rst = 0; det_in = 1;
    tick();
    det_in = 0;
    total++; if (out_valid !== 1'b1 || out_ts !== 16'd0) $display("FAIL first_edge_ts got v=%0d ts=%0d exp v=1 ts=0", out_valid, out_ts); else pass_cnt++;
  endtask

  task automatic test_single_event();
    do_clear();
    tick(5);
    det_in = 1;
    tick();
    det_in = 0;
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %0d exp 1", out_valid); else pass_cnt++;
    total++; if (out_ts !== 16'd5) $display("FAIL single_ts got %0d exp 5", out_ts); else pass_cnt++;
    total++; if (evt_count !== 16'd1) $display("FAIL single_evt got %0d exp 1", evt_count); else pass_cnt++;
    out_ready = 1;
    tick();
    out_ready = 0;
    total++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) $display("FAIL single_pop got v=%0d lvl=%0d exp v=0 lvl=0", out_valid, fifo_level); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_clear();
    det_in = 1;
    tick();
    out_ready = 1;
    tick();
    det_in = 0; out_ready = 0;
    total++; if (fifo_level !== 4'd1 || out_ts !== 16'd1) $display("FAIL b2b_level1 got lvl=%0d ts=%0d exp lvl=1 ts=1", fifo_level, out_ts); else pass_cnt++;
    total++; if (evt_count !== 16'd2) $display("FAIL b2b_evt got %0d exp 2", evt_count); else pass_cnt++;
  endtask

  task automatic test_overflow_and_full_pushpop();
    do_clear();
    tick(10);
    det_in = 1;
    tick(10);
    det_in = 0;
    total++; if (fifo_level !== 4'd8) $display("FAIL ovf_level got %0d exp 8", fifo_level); else pass_cnt++;
    total++; if (drop_count !== 16'd2) $display("FAIL ovf_drop got %0d exp 2", drop_count); else pass_cnt++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0d exp 1", overflow); else pass_cnt++;
    total++; if (evt_count !== 16'd10) $display("FAIL ovf_evt got %0d exp 10", evt_count); else pass_cnt++;
    tick();
    total++; if (out_ts !== 16'd10) $display("FAIL ovf_head_stable got %0d exp 10", out_ts); else pass_cnt++;
    det_in = 1; out_ready = 1;
    tick();
    det_in = 0;
    total++; if (fifo_level !== 4'd8 || drop_count !== 16'd2) $display("FAIL full_pushpop got lvl=%0d drop=%0d exp lvl=8 drop=2", fifo_level, drop_count); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_ts !== ((i < 7) ? 16'(11 + i) : 16'd21)) $display("FAIL drain_%0d got %0d exp %0d", i, out_ts, (i < 7) ? 11 + i : 21);
      else pass_cnt++;
      tick();
    end
    out_ready = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL drain_empty got %0d exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_wrap();
    clear_w = 1;
    tick();
    clear_w = 0;
    tick(14);
    det_w = 1;
    tick();
    det_w = 0;
    tick(2);
    det_w = 1;
    tick();
    det_w = 0;
    total++; if (level_w !== 4'd2 || ts_w !== 4'd14) $display("FAIL wrap_first got lvl=%0d ts=%0d exp lvl=2 ts=14", level_w, ts_w); else pass_cnt++;
    ready_w = 1;
    tick();
    ready_w = 0;
    total++; if (ts_w !== 4'd1 || ovf_w !== 1'b0) $display("FAIL wrap_second got ts=%0d ovf=%0d exp ts=1 ovf=0", ts_w, ovf_w); else pass_cnt++;
  endtask

  task automatic test_clear();
    do_clear();
    det_in = 1;
    tick(9);
    det_in = 0; out_ready = 1;
    tick(5);
    out_ready = 0;
    total++; if (fifo_level !== 4'd3 || overflow !== 1'b1) $display("FAIL clear_setup got lvl=%0d ovf=%0d exp lvl=3 ovf=1", fifo_level, overflow); else pass_cnt++;
    clear = 1; det_in = 1;
    tick();
    clear = 0; det_in = 0;
    total++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) $display("FAIL clear_fifo got v=%0d lvl=%0d exp 0 0", out_valid, fifo_level); else pass_cnt++;
    total++; if (evt_count !== 16'd0 || drop_count !== 16'd0 || overflow !== 1'b0) $display("FAIL clear_counts got evt=%0d drop=%0d ovf=%0d exp 0 0 0", evt_count, drop_count, overflow); else pass_cnt++;
    det_in = 1;
    tick();
    det_in = 0;
    total++; if (out_ts !== 16'd0 || evt_count !== 16'd1) $display("FAIL clear_next got ts=%0d evt=%0d exp ts=0 evt=1", out_ts, evt_count); else pass_cnt++;
  endtask

  task automatic test_system();
    logic [13:0] bits;
    int st;
    bits = 14'b00110001010101;
    st = 0;
    do_clear();
    for (int i = 13; i >= 0; i--) begin
      det_in = (st == 2) && bits[i];
      tick();
      st = det_in ? 0 : bits[i] ? 1 : (st == 1) ? 2 : 0;
    end
    det_in = 0;
    total++; if (fifo_level !== 4'd2 || evt_count !== 16'd2) $display("FAIL sys_count got lvl=%0d evt=%0d exp 2 2", fifo_level, evt_count); else pass_cnt++;
    total++; if (out_ts !== 16'd9) $display("FAIL sys_ts0 got %0d exp 9", out_ts); else pass_cnt++;
    out_ready = 1;
    tick();
    out_ready = 0;
    total++; if (out_ts !== 16'd13) $display("FAIL sys_ts1 got %0d exp 13", out_ts); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_back_to_back();
    test_overflow_and_full_pushpop();
    test_wrap();
    test_clear();
    test_system();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/det_event_logger.md
Name: det_event_logger

Overview:
Downstream consumer of the serial "101" sequence detector's `detected` output.
- Timestamps every detection pulse against a free-running cycle counter.
- Buffers the timestamps in a small FIFO.
- Keeps a saturating total-detection count and a sticky overflow flag.
- A host/bench drains timestamps through a valid/ready read port, so detections are never lost silently while the reader stalls.

Parameters:
- TS_W, 16: width of the free-running timestamp counter and of each FIFO entry.
- DEPTH, 8: FIFO entries; power of 2, ≥ 2.
- CNT_W, 16: width of the total-detection and dropped-event counters.

Ports:
- clk  input  1  rising-edge clock, shared with the detector.
- rst  input  1  reset, synchronous, active-high.
- clear  input  1  synchronous soft clear (same effect as rst, lower priority).
- det_in  input  1  detection pulse, connected to the detector's `detected`; sampled at posedge.
- out_valid  output  1  FIFO non-empty; out_ts holds the oldest timestamp.
- out_ready  input  1  reader accepts out_ts this cycle.
- out_ts  output  TS_W  oldest buffered timestamp.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- evt_count  output  CNT_W  total detections seen (accepted + dropped), saturating.
- drop_count  output  CNT_W  detections dropped on a full FIFO, saturating.
- overflow  output  1  sticky; set on the first drop.

Behaviour:
- One clock; reset is synchronous and active-high (`clk`, `rst`). All state changes happen on posedge clk only.
- Reset (rst=1 at posedge):
  - ts counter = 0, FIFO empty, fifo_level = 0.
  - out_valid = 0, out_ts = 0.
  - evt_count = 0, drop_count = 0, overflow = 0.
- clear=1 at posedge: identical to reset. rst takes priority; det_in and out_ready are ignored that cycle.
- Timestamp counter ts:
  - Increments by 1 at every non-reset, non-clear posedge.
  - Wraps 2^TS_W-1 → 0 with no flag.
- Push on det_in=1 at a posedge:
  - The captured value is ts *before* that edge's increment. So the first edge after reset release captures 0.
  - evt_count += 1, holding at 2^CNT_W-1.
  - If FIFO not full, or full with a pop in the same cycle: write the entry, level updates accordingly.
  - Otherwise: drop the entry, drop_count += 1 (saturating), overflow ← 1.
- Pop: occurs when out_valid && out_ready at a posedge; the head advances.
  - out_ready while empty: no effect.
- Simultaneous push and pop:
  - Level unchanged; both occur, including when full or when level = 1.
  - Push into an empty FIFO with no pop: out_valid = 1 and out_ts = the new timestamp in the cycle after the edge. Latency is 1 cycle.
- FIFO organisation:
  - Circular buffer with wr/rd pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 → 0.
  - full = (level == DEPTH); empty = (level == 0).
  - out_ts is driven from memory[rd_ptr]. It is stable while out_valid=1 and out_ready=0.
- det_in held high for N consecutive edges records N events. The detector is non-overlapping, so consecutive pulses are legal only as separate detections.
- overflow stays set until rst or clear.

Test Plan:
- Reset: rst high 2 cycles, det_in=0 → all outputs 0. ts reads 0 at the first edge after release.
- Single event: after release, det_in=1 only at edge 5 (ts=5) → next cycle out_valid=1, out_ts=5, evt_count=1. Pulse out_ready → out_valid=0, fifo_level=0.
- Fill/overflow, DEPTH=8, out_ready=0: 10 pulses at ts 10..19 →
  - fifo_level=8, drop_count=2, overflow=1, evt_count=10.
  - Draining yields 10,11,…,17.
- Full with simultaneous push+pop: FIFO full, det_in=1 and out_ready=1 at the same edge →
  - level stays 8, drop_count unchanged.
  - The new timestamp appears last on drain.
- Wrap: TS_W=4, pulses at ts 14 and at the 3rd edge after (ts 1) → out_ts sequence 14, 1. No flag.
- Clear mid-operation: 3 entries buffered, overflow=1, clear=1 with det_in=1 →
  - All counters 0, out_valid=0.
  - That pulse is not recorded; the next pulse records ts=0.
- System: chain the 101 detector → this block with input 0011000101010 1 → the logged timestamps match the edges where detected=1.
